// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex font, segment bit positions, edit opcodes
// and the pattern encoder used by the scan logic.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Element 15 is listed first; HEX_FONT[n] is the {g..a} pattern for nibble n.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_LOAD,
        OP_BKSP,
        OP_KEY
    } edit_op_e;

    function automatic logic [7:0] seg7_encode(input logic [3:0] nibble,
                                               input logic       blank,
                                               input logic       dp);
        logic [7:0] pat;
        pat = 8'h00;
        pat[SEG_DP] = dp;
        if (!blank) begin
            pat[SEG_G:SEG_A] = HEX_FONT[nibble];
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, counter wraps 0..DIV-1.
module seg7_tick_gen #(
    parameter int DIV = 25000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(DIV - 1));

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_entry_scan.sv
// Keypad entry buffer with clear/backspace/load editing, time-multiplexed onto
// a DIGITS-wide seven-segment display with registered SEL/SEG.
module seg7_entry_scan
    import seg7_pkg::*;
#(
    parameter int   DIGITS      = 8,
    parameter int   SCAN_DIV    = 25000,
    parameter logic SEL_ACTIVE  = 1'b0,
    parameter logic SEG_ACTIVE  = 1'b1,
    parameter logic BLANK_EMPTY = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         key_valid,
    input  logic [3:0]                   key_value,
    input  logic                         bksp,
    input  logic                         clr,
    input  logic                         load_en,
    input  logic [4*DIGITS-1:0]          load_data,
    input  logic [DIGITS-1:0]            dp,
    output logic [4*DIGITS-1:0]          disp_data,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic [DIGITS-1:0]            SEL,
    output logic [7:0]                   SEG
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int IDX_W = $clog2(DIGITS);

    logic [4*DIGITS-1:0] r_data;
    logic [CNT_W-1:0]    r_count;
    logic [IDX_W-1:0]    r_idx;
    logic                r_scan_on;
    logic [DIGITS-1:0]   r_sel;
    logic [7:0]          r_seg;

    edit_op_e            w_op;
    logic [4*DIGITS-1:0] w_data_nxt;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_tick;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_blank;
    logic [7:0]          w_pat;
    logic [DIGITS-1:0]   w_sel_nxt;
    logic [7:0]          w_seg_nxt;

    seg7_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .tick (w_tick)
    );

    // Only the highest-priority strobe acts in a given cycle.
    always_comb begin
        w_op = OP_NONE;
        if (clr) begin
            w_op = OP_CLR;
        end else if (load_en) begin
            w_op = OP_LOAD;
        end else if (bksp) begin
            w_op = OP_BKSP;
        end else if (key_valid) begin
            w_op = OP_KEY;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_data_nxt  = r_data;
        w_count_nxt = r_count;
        case (w_op)
            OP_CLR: begin
                w_data_nxt  = '0;
                w_count_nxt = '0;
            end
            OP_LOAD: begin
                w_data_nxt  = load_data;
                w_count_nxt = CNT_W'(DIGITS);
            end
            OP_BKSP: begin
                if (r_count != '0) begin
                    w_data_nxt  = {4'h0, r_data[4*DIGITS-1:4]};
                    w_count_nxt = r_count - 1'b1;
                end
            end
            OP_KEY: begin
                w_data_nxt = {r_data[4*DIGITS-5:0], key_value};
                if (r_count != CNT_W'(DIGITS)) begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: begin
                w_data_nxt  = r_data;
                w_count_nxt = r_count;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_data  <= w_data_nxt;
            r_count <= w_count_nxt;
        end
    end

    // The first tick after reset lands on digit 0 rather than advancing past it.
    always_comb begin
        w_idx_nxt = r_idx;
        if (!r_scan_on || (r_idx == IDX_W'(DIGITS - 1))) begin
            w_idx_nxt = '0;
        end else begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    always_comb begin
        w_blank   = BLANK_EMPTY && (int'(w_idx_nxt) >= int'(r_count));
        w_pat     = seg7_encode(r_data[{w_idx_nxt, 2'b00} +: 4], w_blank, dp[w_idx_nxt]);
        w_seg_nxt = SEG_ACTIVE ? w_pat : ~w_pat;
        w_sel_nxt = {DIGITS{~SEL_ACTIVE}};
        w_sel_nxt[w_idx_nxt] = SEL_ACTIVE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx     <= '0;
            r_scan_on <= 1'b0;
            r_sel     <= {DIGITS{~SEL_ACTIVE}};
            r_seg     <= {8{~SEG_ACTIVE}};
        end else if (w_tick) begin
            r_idx     <= w_idx_nxt;
            r_scan_on <= 1'b1;
            r_sel     <= w_sel_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    assign disp_data = r_data;
    assign count     = r_count;
    assign SEL       = r_sel;
    assign SEG       = r_seg;

endmodule

// File: tb/tb_seg7_entry_scan.sv
// Scoreboard bench: instance A (common cathode, active-low SEL) is checked by a
// queue-driven monitor; instance B (common anode, active-high SEL) covers reset.
module tb_seg7_entry_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        key_valid_a = 1'b0, bksp_a = 1'b0, clr_a = 1'b0, load_en_a = 1'b0;
    logic [3:0]  key_value_a = 4'h0;
    logic [15:0] load_data_a = 16'h0;
    logic [3:0]  dp_a = 4'h0;
    logic [15:0] disp_a;
    logic [2:0]  count_a;
    logic [3:0]  sel_a;
    logic [7:0]  seg_a;

    logic        key_valid_b = 1'b0;
    logic [3:0]  key_value_b = 4'h0;
    logic [15:0] disp_b;
    logic [2:0]  count_b;
    logic [3:0]  sel_b;
    logic [7:0]  seg_b;

    seg7_entry_scan #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEL_ACTIVE(1'b0), .SEG_ACTIVE(1'b1), .BLANK_EMPTY(1'b1)
    ) u_dut_a (
        .CLK(clk), .RST(rst_a), .key_valid(key_valid_a), .key_value(key_value_a),
        .bksp(bksp_a), .clr(clr_a), .load_en(load_en_a), .load_data(load_data_a),
        .dp(dp_a), .disp_data(disp_a), .count(count_a), .SEL(sel_a), .SEG(seg_a)
    );

    seg7_entry_scan #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEL_ACTIVE(1'b1), .SEG_ACTIVE(1'b0), .BLANK_EMPTY(1'b1)
    ) u_dut_b (
        .CLK(clk), .RST(rst_b), .key_valid(key_valid_b), .key_value(key_value_b),
        .bksp(1'b0), .clr(1'b0), .load_en(1'b0), .load_data(16'h0),
        .dp(4'h0), .disp_data(disp_b), .count(count_b), .SEL(sel_b), .SEG(seg_b)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        int         slot;
    } scan_exp_t;

    typedef struct {
        logic [15:0] disp;
        logic [2:0]  cnt;
    } edit_exp_t;

    scan_exp_t scan_q[$];
    edit_exp_t edit_q[$];

    int checks   = 0;
    int failures = 0;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0] m_disp = 16'h0;
    logic [2:0]  m_cnt  = 3'd0;
    int          edge_num = 0;
    int          tick_num = 0;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected SEL/SEG for the slot that the upcoming tick edge opens.
    task automatic push_scan();
        scan_exp_t  e;
        int         d;
        logic [6:0] g;
        d = tick_num % DIGITS;
        g = (d >= int'(m_cnt)) ? 7'h00 : font[m_disp[4*d +: 4]];
        e.sel  = ~(4'b0001 << d);
        e.seg  = {dp_a[d], g};
        e.slot = tick_num;
        scan_q.push_back(e);
        tick_num++;
    endtask

    // One clock of stimulus on A, entered and left at a falling edge.
    task automatic step(input logic kv, input logic [3:0] kval, input logic bk,
                        input logic cl, input logic ld, input logic [15:0] ldata,
                        input logic [15:0] e_disp, input logic [2:0] e_cnt);
        edit_exp_t ee;
        key_valid_a = kv;
        key_value_a = kval;
        bksp_a      = bk;
        clr_a       = cl;
        load_en_a   = ld;
        load_data_a = ldata;
        edge_num++;
        if (edge_num % SCAN_DIV == 0) push_scan();
        if (kv || bk || cl || ld) begin
            ee.disp = e_disp;
            ee.cnt  = e_cnt;
            edit_q.push_back(ee);
            m_disp = e_disp;
            m_cnt  = e_cnt;
        end
        @(negedge clk);
        key_valid_a = 1'b0;
        bksp_a      = 1'b0;
        clr_a       = 1'b0;
        load_en_a   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, m_disp, m_cnt);
    endtask

    initial begin : monitor
        logic [3:0] prev_sel;
        logic       seen;
        scan_exp_t  se;
        edit_exp_t  ee;
        wait (mon_en);
        prev_sel = 4'b1111;
        forever begin
            @(posedge clk);
            seen = key_valid_a | bksp_a | clr_a | load_en_a;
            @(negedge clk);
            if (mon_en) begin
                if (seen) begin
                    if (edit_q.size() == 0) begin
                        check("edit_unexpected", 32'd1, 32'd0);
                    end else begin
                        ee = edit_q.pop_front();
                        check("edit_disp", 32'(disp_a), 32'(ee.disp));
                        check("edit_count", 32'(count_a), 32'(ee.cnt));
                    end
                end
                if (sel_a !== prev_sel) begin
                    if (scan_q.size() == 0) begin
                        check("scan_unexpected", 32'(sel_a), 32'(prev_sel));
                    end else begin
                        se = scan_q.pop_front();
                        check($sformatf("scan_sel_slot%0d", se.slot), 32'(sel_a), 32'(se.sel));
                        check($sformatf("scan_seg_slot%0d", se.slot), 32'(seg_a), 32'(se.seg));
                    end
                end
                prev_sel = sel_a;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_disp", 32'(disp_a), 32'h0);
        check("reset_count", 32'(count_a), 32'h0);
        check("reset_sel", 32'(sel_a), 32'hF);
        check("reset_seg", 32'(seg_a), 32'h00);
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        mon_en = 1'b1;

        idle(16);

        step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0001, 3'd1);
        step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0012, 3'd2);
        step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0123, 3'd3);
        idle(16);

        step(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0, 16'h1234, 3'd4);
        step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0, 16'h2345, 3'd4);
        idle(16);

        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0234, 3'd3);
        step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0023, 3'd2);
        idle(8);

        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 3'd0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0000, 3'd0);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 3'd4);
        dp_a = 4'b0001;
        idle(16);

        step(1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0, 16'hEEF7, 3'd4);
        idle(8);

        @(posedge clk);
        mon_en = 1'b0;
        #1;
        check("scan_queue_drained", 32'(scan_q.size()), 32'd0);
        check("edit_queue_drained", 32'(edit_q.size()), 32'd0);

        // Instance B: inverted polarities and asynchronous mid-slot reset.
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b       = 1'b0;
        key_valid_b = 1'b1;
        key_value_b = 4'h8;
        @(negedge clk);
        key_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        check("b_count", 32'(count_b), 32'd1);
        check("b_disp", 32'(disp_b), 32'h0008);
        check("b_sel_digit0", 32'(sel_b), 32'h1);
        check("b_seg_digit0", 32'(seg_b), 32'h80);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("b_async_sel", 32'(sel_b), 32'h0);
        check("b_async_seg", 32'(seg_b), 32'hFF);
        check("b_async_count", 32'(count_b), 32'd0);
        check("b_async_disp", 32'(disp_b), 32'h0);
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("b_restart_pre_tick_sel", 32'(sel_b), 32'h0);
        @(negedge clk);
        check("b_restart_sel", 32'(sel_b), 32'h1);
        check("b_restart_seg", 32'(seg_b), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
